// File: rtl/codec_config_seq.sv
// WM8731 power-up sequencer: walks a fixed register table and drives a byte-level i2c engine
// through four-phase start/write/stop handshakes, retrying NACKed entries up to MAX_RETRY times.
module codec_config_seq #(
  parameter logic [7:0]  DEV_ADDR    = 8'h34,
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       go,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic       i2c_write,
  output logic [7:0] i2c_data,
  input  logic       i2c_done,
  input  logic       i2c_status,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [3:0] err_index
);

  typedef enum logic [3:0] {
    StIdle,
    StStartReq,
    StStartRel,
    StDevReq,
    StDevRel,
    StRegHReq,
    StRegHRel,
    StRegLReq,
    StRegLRel,
    StStopReq,
    StStopRel,
    StNext
  } state_e;

  localparam logic [3:0] LastIndex = 4'(NUM_ENTRIES - 1);
  localparam logic [2:0] MaxRetry  = 3'(MAX_RETRY);

  state_e      state_q;
  state_e      succ;
  logic [3:0]  index_q;
  logic [2:0]  retry_q;
  logic        nack_q;
  logic [15:0] entry;
  logic [7:0]  cur_byte;

  // Entry packed as {reg[6:0], data[8:0]} so the second byte is simply entry[15:8].
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    unique case (idx)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h067};
      4'd2:    table_entry = {7'd2,  9'h079};
      4'd3:    table_entry = {7'd3,  9'h079};
      4'd4:    table_entry = {7'd4,  9'h012};
      4'd5:    table_entry = {7'd5,  9'h000};
      4'd6:    table_entry = {7'd7,  9'h00A};
      4'd7:    table_entry = {7'd9,  9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  always_comb begin
    entry    = table_entry(index_q);
    cur_byte = DEV_ADDR;
    if (state_q == StRegHReq) cur_byte = entry[15:8];
    if (state_q == StRegLReq) cur_byte = entry[7:0];
  end

  // Successor through the byte phases when no NACK diverts the walk.
  always_comb begin
    succ = state_q;
    unique case (state_q)
      StDevReq:  succ = StDevRel;
      StDevRel:  succ = StRegHReq;
      StRegHReq: succ = StRegHRel;
      StRegHRel: succ = StRegLReq;
      StRegLReq: succ = StRegLRel;
      StRegLRel: succ = StStopReq;
      default:   succ = state_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      index_q   <= '0;
      retry_q   <= '0;
      nack_q    <= 1'b0;
      i2c_start <= 1'b0;
      i2c_stop  <= 1'b0;
      i2c_write <= 1'b0;
      i2c_data  <= '0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      err_index <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_index <= '0;
            index_q   <= '0;
            retry_q   <= '0;
            nack_q    <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StStartReq;
          end
        end
        StStartReq: begin
          if (!i2c_start) begin
            if (!i2c_done) i2c_start <= 1'b1;
          end else if (i2c_done) begin
            i2c_start <= 1'b0;
            state_q   <= StStartRel;
          end
        end
        StStartRel: begin
          if (!i2c_done) state_q <= StDevReq;
        end
        StDevReq, StRegHReq, StRegLReq: begin
          if (!i2c_write) begin
            if (!i2c_done) begin
              i2c_write <= 1'b1;
              i2c_data  <= cur_byte;
            end
          end else if (i2c_done) begin
            i2c_write <= 1'b0;
            nack_q    <= i2c_status;
            state_q   <= succ;
          end
        end
        StDevRel, StRegHRel, StRegLRel: begin
          if (!i2c_done) state_q <= nack_q ? StStopReq : succ;
        end
        StStopReq: begin
          if (!i2c_stop) begin
            if (!i2c_done) i2c_stop <= 1'b1;
          end else if (i2c_done) begin
            i2c_stop <= 1'b0;
            state_q  <= StStopRel;
          end
        end
        StStopRel: begin
          if (!i2c_done) begin
            if (!nack_q) begin
              state_q <= StNext;
            end else if (retry_q < MaxRetry) begin
              retry_q <= retry_q + 3'd1;
              nack_q  <= 1'b0;
              state_q <= StStartReq;
            end else begin
              cfg_error <= 1'b1;
              err_index <= index_q;
              busy      <= 1'b0;
              state_q   <= StIdle;
            end
          end
        end
        StNext: begin
          if (index_q == LastIndex) begin
            cfg_done <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end else begin
            index_q <= index_q + 4'd1;
            retry_q <= '0;
            state_q <= StStartReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
